gray_counter_n: RTL

- Parametrised Gray-code counter. Successor to the fixed 2-bit, up-only Gray counter FSM.
- Generalises width. Adds count enable, up/down direction, synchronous load, wrap or saturate mode, terminal-count flag and wrap pulse.
- Used as a glitch-free position/pointer source, for example FIFO pointers crossing clock domains and rotary/phase sequencing.
- All state outputs are registered, so every count step changes exactly one bit of gray.

---
 rtl/gray_counter_n.sv | 62 ++++++
 1 files changed

// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: up/down, enable, synchronous load, wrap or saturate.
// bin and gray are both registered from the same next-state value, so gray never glitches.
module gray_counter_n #(
    parameter int          WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;
    logic             next_sat;

    // Terminal value depends on the direction currently requested.
    assign tc = up ? (bin == MAX_VAL) : (bin == '0);

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        next_sat  = sat;
        if (load) begin
            next_bin = load_val;
            next_sat = 1'b0;
        end else if (en) begin
            if (SATURATE && tc) begin
                next_sat = 1'b1;
            end else begin
                next_bin  = up ? bin + WIDTH'(1) : bin - WIDTH'(1);
                next_wrap = !SATURATE && tc;
                next_sat  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= RST_BIN;
            gray <= RST_GRAY;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= next_bin ^ (next_bin >> 1);
            wrap <= next_wrap;
            sat  <= next_sat;
        end
    end
endmodule
